// File: rtl/order_feed_sequencer.sv
// order_feed_sequencer
// Assembles 11-byte big-endian order messages from a byte feed. Valid messages
// are buffered in a FIFO. The block then issues each one as a single-cycle
// order strobe to the book, and waits for the book's busy flag between issues.
// Optional feature: define ORDER_FEED_DROP_CNT_EN to enable the saturating
// malformed-message counter. When it is undefined, o_drop_count is tied to 0.
module order_feed_sequencer #(
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  input  logic          i_rx_sof,
  output logic          o_rx_ready,
  input  logic          i_book_is_busy,
  output logic          o_order_valid,
  output logic [1:0]    o_stock_id,
  output logic [1:0]    o_order_type,
  output logic [15:0]   o_quantity,
  output logic [31:0]   o_price,
  output logic [31:0]   o_order_id,
  output logic [CW-1:0] o_fifo_count,
  output logic [15:0]   o_drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 84;  // {type, stock, qty, price, id}

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Header rule: upper nibble clear and order type 3 reserved.
  function automatic logic hdr_ok(input logic [7:0] hdr);
    return (hdr[7:4] == 4'd0) && (hdr[3:2] != 2'd3);
  endfunction

  logic [3:0]    byte_idx_r;
  logic [79:0]   shift_r;
  logic [87:0]   msg_s;
  logic          accept_s;
  logic          msg_done_s;
  logic          push_s;
  logic          pop_s;
  state_t        state_r;
  state_t        state_next_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [EW-1:0] head_s;

  assign o_rx_ready   = (count_r != CW'(FIFO_DEPTH));
  assign o_fifo_count = count_r;
  assign accept_s     = i_rx_valid & o_rx_ready;
  // A non-SOF byte at index 10 is the last byte of an open message.
  assign msg_done_s   = accept_s & ~i_rx_sof & (byte_idx_r == 4'd10);
  assign msg_s        = {shift_r, i_rx_data};
  assign push_s       = msg_done_s & hdr_ok(msg_s[87:80]);
  assign head_s       = mem_r[rd_ptr_r];

  // Byte assembler: SOF restarts at index 1 after byte 0; idle non-SOF bytes are ignored.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byte_idx_r <= 4'd0;
      shift_r    <= 80'd0;
    end else if (accept_s) begin
      if (i_rx_sof) begin
        byte_idx_r <= 4'd1;
        shift_r    <= {72'd0, i_rx_data};
      end else if (byte_idx_r == 4'd10) begin
        byte_idx_r <= 4'd0;
      end else if (byte_idx_r != 4'd0) begin
        byte_idx_r <= byte_idx_r + 4'd1;
        shift_r    <= {shift_r[71:0], i_rx_data};
      end
    end
  end

  // FIFO storage: the payload needs no reset because occupancy is tracked separately.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= msg_s[EW-1:0];
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Drain FSM next state: issue from IDLE, then spend GAP and HOLD so busy can rise.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != {CW{1'b0}}) && !i_book_is_busy) begin
          pop_s        = 1'b1;
          state_next_s = ST_GAP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GAP:  state_next_s = ST_HOLD;
      ST_HOLD: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output field registers: load from the FIFO head on issue and hold otherwise.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_order_valid <= 1'b0;
      o_order_type  <= 2'd0;
      o_stock_id    <= 2'd0;
      o_quantity    <= 16'd0;
      o_price       <= 32'd0;
      o_order_id    <= 32'd0;
    end else begin
      o_order_valid <= pop_s;
      if (pop_s) begin
        o_order_type <= head_s[83:82];
        o_stock_id   <= head_s[81:80];
        o_quantity   <= head_s[79:64];
        o_price      <= head_s[63:32];
        o_order_id   <= head_s[31:0];
      end
    end
  end

`ifdef ORDER_FEED_DROP_CNT_EN
  logic        drop_s;
  logic [15:0] drop_cnt_r;

  assign drop_s       = msg_done_s & ~hdr_ok(msg_s[87:80]);
  assign o_drop_count = drop_cnt_r;

  // Saturating count of malformed messages.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end
`else
  assign o_drop_count = 16'd0;
`endif

endmodule
